// File: rtl/mtrap_irq_ctrl.sv
// mtrap_irq_ctrl: mtime/mtimecmp timer, MSIP and external irq source on the data bus.
// Define MTIME_SNAPSHOT_EN to latch MTIME_HI into a shadow on every MTIME_LO read.
module mtrap_irq_ctrl #(
  parameter logic [31:0] BASE_ADR     = 32'h0000_2000,
  parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] d_in,
  input  logic        mrd,
  input  logic        mwr,
  output logic [31:0] d_out,
  input  logic        ext_irq,
  output logic        machineTimerInterrupt,
  output logic        machineSoftwareInterrupt,
  output logic        machineExternalInterrupt
);

  localparam logic [2:0] OFF_MSIP  = 3'd0;
  localparam logic [2:0] OFF_CMPLO = 3'd1;
  localparam logic [2:0] OFF_CMPHI = 3'd2;
  localparam logic [2:0] OFF_MTLO  = 3'd3;
  localparam logic [2:0] OFF_MTHI  = 3'd4;
  localparam logic [2:0] OFF_EXT   = 3'd5;
  localparam logic [2:0] OFF_PRE   = 3'd6;

  logic        hit;
  logic [2:0]  off;
  logic        rd_en;
  logic        wr_en;
  logic        unused_adr;

  assign hit        = (adr[31:5] == BASE_ADR[31:5]);
  assign off        = adr[4:2];
  assign rd_en      = hit & mrd;
  assign wr_en      = hit & mwr;
  assign unused_adr = ^adr[1:0];

  logic we_msip;
  logic we_cmplo;
  logic we_cmphi;
  logic we_mtlo;
  logic we_mthi;
  logic we_ext;
  logic we_pre;

  assign we_msip  = wr_en & (off == OFF_MSIP);
  assign we_cmplo = wr_en & (off == OFF_CMPLO);
  assign we_cmphi = wr_en & (off == OFF_CMPHI);
  assign we_mtlo  = wr_en & (off == OFF_MTLO);
  assign we_mthi  = wr_en & (off == OFF_MTHI);
  assign we_ext   = wr_en & (off == OFF_EXT);
  assign we_pre   = wr_en & (off == OFF_PRE);

  logic        msip;
  logic [31:0] cmp_lo;
  logic [31:0] cmp_hi;
  logic [31:0] mtime_lo;
  logic [31:0] mtime_hi;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic        mti;

  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtime_inc;
  logic [31:0] lo_nxt;
  logic [31:0] hi_nxt;
  logic [31:0] hi_rd;

  assign tick      = (pcnt == prescale);
  assign mtime     = {mtime_hi, mtime_lo};
  assign mtime_inc = mtime + 64'd1;

  // A write owns its half; a HI write still lets LO count, dropping its carry.
  always_comb begin
    lo_nxt = mtime_lo;
    hi_nxt = mtime_hi;
    if (tick) begin
      lo_nxt = mtime_inc[31:0];
      hi_nxt = mtime_inc[63:32];
    end
    if (we_mtlo) begin
      lo_nxt = d_in;
      hi_nxt = mtime_hi;
    end
    if (we_mthi) begin
      hi_nxt = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip     <= 1'b0;
      cmp_lo   <= 32'hFFFF_FFFF;
      cmp_hi   <= 32'hFFFF_FFFF;
      mtime_lo <= 32'h0;
      mtime_hi <= 32'h0;
      prescale <= PRESCALE_RST;
      pcnt     <= 16'h0;
      mti      <= 1'b0;
    end else begin
      if (we_msip) msip <= d_in[0];
      if (we_cmplo) cmp_lo <= d_in;
      if (we_cmphi) cmp_hi <= d_in;
      if (we_pre) prescale <= d_in[15:0];
      mtime_lo <= lo_nxt;
      mtime_hi <= hi_nxt;
      if (we_pre || tick) pcnt <= 16'h0;
      else pcnt <= pcnt + 16'd1;
      mti <= (mtime >= {cmp_hi, cmp_lo});
    end
  end

  logic sync1;
  logic sync2;
  logic sync_q;
  logic ext_rise;
  logic ext_pend;
  logic ext_en;
  logic mei;

  assign ext_rise = sync2 & ~sync_q;

  // New edge beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_q   <= 1'b0;
      ext_pend <= 1'b0;
      ext_en   <= 1'b0;
      mei      <= 1'b0;
    end else begin
      sync1  <= ext_irq;
      sync2  <= sync1;
      sync_q <= sync2;
      if (ext_rise) ext_pend <= 1'b1;
      else if (we_ext && d_in[0]) ext_pend <= 1'b0;
      if (we_ext) ext_en <= d_in[1];
      mei <= ext_pend & ext_en;
    end
  end

`ifdef MTIME_SNAPSHOT_EN
  logic [31:0] mthi_shd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mthi_shd <= 32'h0;
    end else if (rd_en && (off == OFF_MTLO)) begin
      mthi_shd <= mtime_hi;
    end
  end

  assign hi_rd = mthi_shd;
`else
  assign hi_rd = mtime_hi;
`endif

  always_comb begin
    d_out = 32'h0;
    if (rd_en) begin
      unique case (off)
        OFF_MSIP:  d_out = {31'h0, msip};
        OFF_CMPLO: d_out = cmp_lo;
        OFF_CMPHI: d_out = cmp_hi;
        OFF_MTLO:  d_out = mtime_lo;
        OFF_MTHI:  d_out = hi_rd;
        OFF_EXT:   d_out = {30'h0, ext_en, ext_pend};
        OFF_PRE:   d_out = {16'h0, prescale};
        default:   d_out = 32'h0;
      endcase
    end
  end

  assign machineTimerInterrupt    = mti;
  assign machineSoftwareInterrupt = msip;
  assign machineExternalInterrupt = mei;

endmodule

// File: tb/tb_mtrap_irq_ctrl.sv
// tb_mtrap_irq_ctrl: directed scoreboard bench for mtrap_irq_ctrl.
// Expected values are queued as stimulus is applied and popped against DUT outputs.
module tb_mtrap_irq_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] O_MSIP = 32'h00;
  localparam logic [31:0] O_CMPL = 32'h04;
  localparam logic [31:0] O_CMPH = 32'h08;
  localparam logic [31:0] O_MTL  = 32'h0C;
  localparam logic [31:0] O_MTH  = 32'h10;
  localparam logic [31:0] O_EXT  = 32'h14;
  localparam logic [31:0] O_PRE  = 32'h18;
  localparam logic [31:0] O_UNM  = 32'h1C;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] d_in;
  logic        mrd;
  logic        mwr;
  logic [31:0] d_out;
  logic        ext_irq;
  logic        mti;
  logic        msi;
  logic        mei;

  mtrap_irq_ctrl #(
    .BASE_ADR(BASE),
    .PRESCALE_RST(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adr(adr),
    .d_in(d_in),
    .mrd(mrd),
    .mwr(mwr),
    .d_out(d_out),
    .ext_irq(ext_irq),
    .machineTimerInterrupt(mti),
    .machineSoftwareInterrupt(msi),
    .machineExternalInterrupt(mei)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  string       tq[$];
  logic [31:0] vq[$];
  logic        found;

  task automatic push(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic pop(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    vectors++;
    if (vq.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h, nothing expected", obs);
    end else begin
      tag = tq.pop_front();
      e   = vq.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] e);
    push(tag, e);
    pop(obs);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] v);
    adr  = BASE + off;
    d_in = v;
    mwr  = 1'b1;
    @(posedge clk);
    #1;
    mwr  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string tag);
    push(tag, e);
    adr = a;
    mrd = 1'b1;
    #1;
    pop(d_out);
    mrd = 1'b0;
  endtask

  task automatic rd_hi(input logic [31:0] e, input string tag);
    adr = BASE + O_MTL;
    mrd = 1'b1;
    @(posedge clk);
    #1;
    adr = BASE + O_MTH;
    push(tag, e);
    #1;
    pop(d_out);
    mrd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    adr     = 32'h0;
    d_in    = 32'h0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    ext_irq = 1'b0;
    found   = 1'b0;

    // reset held while a write to MSIP is attempted
    #2 rst = 1'b0;
    adr  = BASE + O_MSIP;
    d_in = 32'h1;
    mwr  = 1'b1;
    cyc(3);
    chk("rst_mti", 32'(mti), 32'h0);
    chk("rst_msi", 32'(msi), 32'h0);
    chk("rst_mei", 32'(mei), 32'h0);
    mwr = 1'b0;
    rd(BASE + O_MSIP, 32'h0, "rst_msip_rd");
    rd(BASE + O_CMPL, 32'hFFFF_FFFF, "rst_cmplo");
    rd(BASE + O_CMPH, 32'hFFFF_FFFF, "rst_cmphi");
    adr = BASE + O_CMPL;
    #1;
    chk("rst_dout_idle", d_out, 32'h0);
    cyc(1);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("post_rst_irqs", {29'h0, mti, msi, mei}, 32'h0);
    end

    // timer compare
    wr(O_PRE, 32'h0);
    wr(O_CMPH, 32'h0);
    wr(O_MTL, 32'h0);
    wr(O_CMPL, 32'd20);
    adr = BASE + O_MTL;
    mrd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (d_out == 32'd20) begin
        found = 1'b1;
        break;
      end
      chk("tmr_pre", 32'(mti), 32'h0);
      cyc(1);
    end
    chk("tmr_seen20", 32'(found), 32'h1);
    chk("tmr_at20", 32'(mti), 32'h0);
    cyc(1);
    chk("tmr_rise", 32'(mti), 32'h1);
    mrd = 1'b0;
    wr(O_CMPL, 32'd1000);
    chk("tmr_hold", 32'(mti), 32'h1);
    cyc(1);
    chk("tmr_fall", 32'(mti), 32'h0);

    // prescale and carry
    wr(O_PRE, 32'd3);
    wr(O_MTH, 32'h0);
    wr(O_MTL, 32'hFFFF_FFFF);
    rd(BASE + O_MTL, 32'hFFFF_FFFF, "pre_lo_set");
    rd_hi(32'h0, "pre_hi_before");
    cyc(1);
    rd(BASE + O_MTL, 32'h0, "carry_lo");
    rd_hi(32'h1, "carry_hi");
    cyc(2);
    wr(O_MTL, 32'h1234);
    rd(BASE + O_MTL, 32'h1234, "wr_beats_inc");
    rd_hi(32'h1, "wr_lo_hi_hold");
    cyc(2);
    rd(BASE + O_MTL, 32'h1234, "pre_wait");
    cyc(1);
    rd(BASE + O_MTL, 32'h1235, "pre_tick");
    chk("tmr_64b_cmp", 32'(mti), 32'h1);

    // software interrupt and decode
    chk("msi_idle", 32'(msi), 32'h0);
    wr(O_MSIP, 32'h1);
    chk("msi_set", 32'(msi), 32'h1);
    rd(BASE + O_MSIP, 32'h1, "msip_rd");
    wr(O_MSIP, 32'h0);
    chk("msi_clr", 32'(msi), 32'h0);
    wr(O_UNM, 32'hFFFF_FFFF);
    rd(BASE + O_UNM, 32'h0, "unmapped_rd");
    rd(BASE + O_MSIP, 32'h0, "unmapped_msip");
    rd(BASE + O_PRE, 32'd3, "unmapped_pre");
    rd(BASE + 32'h1A, 32'd3, "byte_ofs_ign");
    rd(BASE + 32'h20, 32'h0, "miss_rd");

    // external interrupt
    wr(O_EXT, 32'h2);
    rd(BASE + O_EXT, 32'h2, "ext_en");
    cyc(1);
    ext_irq = 1'b1;
    push("ext_lat1", 32'h0);
    push("ext_lat2", 32'h0);
    push("ext_lat3", 32'h0);
    push("ext_lat4", 32'h1);
    push("ext_lat5", 32'h1);
    push("ext_lat6", 32'h1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (i == 2) ext_irq = 1'b0;
      pop(32'(mei));
    end
    wr(O_EXT, 32'h2);
    rd(BASE + O_EXT, 32'h3, "ext_w0_keep");
    wr(O_EXT, 32'h3);
    cyc(1);
    chk("ext_w1c", 32'(mei), 32'h0);
    rd(BASE + O_EXT, 32'h2, "ext_w1c_rd");
    cyc(1);
    ext_irq = 1'b1;
    cyc(2);
    wr(O_EXT, 32'h3);
    rd(BASE + O_EXT, 32'h3, "ext_set_wins");
    cyc(1);
    chk("ext_set_wins_irq", 32'(mei), 32'h1);
    ext_irq = 1'b0;

    // MTIME_HI snapshot across a carry
    wr(O_PRE, 32'hABCD_FFFF);
    rd(BASE + O_PRE, 32'h0000_FFFF, "pre_16b");
    wr(O_MTH, 32'h0);
    wr(O_MTL, 32'hFFFF_FFFF);
    adr = BASE + O_MTL;
    mrd = 1'b1;
    push("snap_lo", 32'hFFFF_FFFF);
    #1;
    pop(d_out);
    cyc(1);
    mrd = 1'b0;
    wr(O_PRE, 32'h0);
    cyc(1);
`ifdef MTIME_SNAPSHOT_EN
    rd(BASE + O_MTH, 32'h0, "snap_hi");
`else
    rd(BASE + O_MTH, 32'h1, "live_hi");
`endif
    rd_hi(32'h1, "pair_hi");

    // asynchronous reset mid-operation
    wr(O_MSIP, 32'h1);
    chk("pre_rst_mti", 32'(mti), 32'h1);
    chk("pre_rst_msi", 32'(msi), 32'h1);
    chk("pre_rst_mei", 32'(mei), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_irqs", {29'h0, mti, msi, mei}, 32'h0);
    rd(BASE + O_CMPL, 32'hFFFF_FFFF, "arst_cmplo");
    rd(BASE + O_MTL, 32'h0, "arst_mtlo");
    rd(BASE + O_EXT, 32'h0, "arst_ext");
    rd(BASE + O_PRE, 32'h0, "arst_pre");
    cyc(1);
    rst = 1'b1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mtrap_irq_ctrl.md
Name: mtrap_irq_ctrl

Overview:
- Memory-mapped machine interrupt source for the RV32I trap pipeline.
- Sits on the CPU data bus beside data_mem, on the same adr/d_in/mrd/mwr/d_out signalling.
- Drives machineTimerInterrupt, machineSoftwareInterrupt and machineExternalInterrupt into riscv_pipeline from three sources:
  - a 64-bit mtime/mtimecmp timer;
  - a software-set MSIP bit;
  - a latched, synchronised external request line.

Parameters:
- BASE_ADR, 32'h0000_2000: base byte address of the 32-byte register window; must be 32-byte aligned.
- PRESCALE_RST, 0: reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- adr  input  32  data-bus byte address.
- d_in  input  32  write data from CPU.
- mrd  input  1  read strobe.
- mwr  input  1  write strobe.
- d_out  output  32  read data; 0 when not selected, so it can be ORed with data_mem output.
- ext_irq  input  1  asynchronous external interrupt request (level, rising edge counts).
- machineTimerInterrupt  output  1  timer interrupt, registered.
- machineSoftwareInterrupt  output  1  MSIP bit 0.
- machineExternalInterrupt  output  1  external pending AND enable, registered.

Behaviour:
- Address decoding:
  - hit = (adr[31:5] == BASE_ADR[31:5]); offset = adr[4:2]; adr[1:0] ignored; word accesses only.
  - Reads are combinational: d_out = register value when hit & mrd, else 0. Unmapped offsets read 0.
  - Writes take effect on the clk edge when hit & mwr. Writes to unmapped offsets are ignored.
- Register map (offset: name, reset value):
  - 0x00 MSIP: bit0 RW, reset 0.
  - 0x04 MTIMECMP_LO: reset FFFF_FFFF.
  - 0x08 MTIMECMP_HI: reset FFFF_FFFF.
  - 0x0C MTIME_LO: reset 0.
  - 0x10 MTIME_HI: reset 0.
  - 0x14 EXTCTL: bit0 pending (read; write 1 clears), bit1 enable (RW), reset 0.
  - 0x18 PRESCALE: 16 bits RW, upper bits read 0, reset PRESCALE_RST.
- Prescaler and mtime:
  - 16-bit prescaler counter, reset 0; counts 0..PRESCALE.
  - When it equals PRESCALE it reloads 0 and mtime increments by 1. PRESCALE=0 means mtime increments every cycle.
  - mtime wraps FFFF_FFFF_FFFF_FFFF -> 0 silently.
  - Write to MTIME_LO: LO takes d_in; HI holds that cycle (no carry).
  - Write to MTIME_HI: HI takes d_in; LO increments normally, carry discarded.
  - Any write wins over a same-cycle increment of that half. A write to PRESCALE also clears the prescaler counter.
- Timer interrupt:
  - machineTimerInterrupt <= (mtime >= mtimecmp), unsigned 64-bit compare, registered.
  - Asserts one cycle after the condition holds and deasserts one cycle after it is removed.
  - Software clears it by rewriting MTIMECMP or MTIME.
- Software interrupt: machineSoftwareInterrupt = MSIP bit0, driven directly from the flop, so it changes on the edge after the write.
- External interrupt:
  - ext_irq passes through a 2-flop synchroniser plus an edge flop; a synchronised 0->1 edge sets pending.
  - Write-1-to-clear of pending in the same cycle as a new edge: set wins, pending stays 1.
  - Writing 0 to bit0 does not change pending.
  - machineExternalInterrupt <= pending & enable, registered.
  - Latency: 4 cycles from ext_irq rising (meeting setup) to output high when enable=1.
- Reset:
  - rst low at any time, including mid-count or mid-write, asynchronously forces all registers, synchroniser flops and all three interrupt outputs to their reset values (outputs 0).
  - d_out is combinational and stays 0 while not selected.

Optional Feature:
- Macro MTIME_SNAPSHOT_EN.
- Defined:
  - Any read of MTIME_LO (hit & mrd, sampled on clk edge) copies current MTIME_HI into a 32-bit shadow.
  - Reads of MTIME_HI return the shadow, so a LO-then-HI read pair is coherent across carry.
  - Shadow resets to 0.
- Undefined: MTIME_HI reads return the live value; no shadow flops exist.

Test Plan:
- Reset: hold rst=0 while writing MSIP=1 -> all outputs 0, MTIMECMP reads FFFF_FFFF, d_out 0 with mrd low; release, no interrupt for 100 cycles.
- Timer: PRESCALE=0, MTIME_LO=0, MTIMECMP_HI=0, MTIMECMP_LO=20 -> machineTimerInterrupt rises exactly 1 cycle after MTIME_LO reads 20; write MTIMECMP_LO=1000 -> falls next cycle.
- Prescale/carry: PRESCALE=3, MTIME_HI=0, MTIME_LO=FFFF_FFFF -> after 4 cycles MTIME_HI=1, MTIME_LO=0; write MTIME_LO the same cycle as increment -> written value kept.
- Software: write MSIP=1 -> machineSoftwareInterrupt high next edge; write 0 -> low next edge; write to offset 0x1C -> no state change, read 0.
- External: EXTCTL enable=1, pulse ext_irq 2 cycles -> machineExternalInterrupt high 4 cycles after rise and stays high; write 1 to EXTCTL bit0 -> low; second edge coincident with clear -> stays high.
- MTIME_SNAPSHOT_EN: mtime=0000_0000_FFFF_FFFF, read LO, let carry occur, read HI -> returns 0; without macro -> returns 1.
